// File: rtl/alu_seq.sv
// Sequential ALU: one request in flight, binary result in CALC, optional BCD
// adjust in ADJ, response held in HOLD until the consumer takes it.
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter int DECIMAL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [1:0]       dbg_state
);

    localparam int NIB = WIDTH / 4;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ADJ = 2'd2, HOLD = 2'd3} state_t;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; in_ready is 1 only in IDLE, out_valid is 1 only in HOLD.

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d, dec_q, dec_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    // Digit-serial BCD add; returns {carry_out, sum}.
    function automatic logic [WIDTH:0] bcd_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic cin);
        logic [WIDTH-1:0] r;
        logic             c;
        logic [5:0]       s;
        r = '0;
        c = cin;
        for (int i = 0; i < NIB; i++) begin
            s = {2'b00, x[4*i +: 4]} + {2'b00, y[4*i +: 4]} + {5'b00000, c};
            if (s > 6'd9) begin
                s = s + 6'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    // Digit-serial BCD subtract; returns {!final_borrow, difference}.
    function automatic logic [WIDTH:0] bcd_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic cin);
        logic [WIDTH-1:0] r;
        logic             bw;
        logic [4:0]       t;
        r  = '0;
        bw = ~cin;
        for (int i = 0; i < NIB; i++) begin
            t = {1'b0, x[4*i +: 4]} - {1'b0, y[4*i +: 4]} - {4'b0000, bw};
            if (t[4]) begin
                r[4*i +: 4] = t[3:0] - 4'd6;
                bw          = 1'b1;
            end else begin
                r[4*i +: 4] = t[3:0];
                bw          = 1'b0;
            end
        end
        return {~bw, r};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bin_res;
    logic             bin_n, bin_z, bin_c, bin_v;
    logic [WIDTH:0]   dec_word;
    logic             go_adj;

    always_comb begin
        b_eff   = (op_q == OP_SBC) ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
        diff    = a_q - b_q;
        bin_res = a_q;
        bin_c   = cin_q;
        bin_v   = 1'b0;
        case (op_q)
            OP_ADC, OP_SBC: begin
                bin_res = sum[WIDTH-1:0];
                bin_c   = sum[WIDTH];
                bin_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: bin_res = a_q & b_q;
            OP_ORA: bin_res = a_q | b_q;
            OP_EOR: bin_res = a_q ^ b_q;
            OP_ASL: begin
                bin_res = {a_q[WIDTH-2:0], 1'b0};
                bin_c   = a_q[WIDTH-1];
            end
            OP_LSR: begin
                bin_res = {1'b0, a_q[WIDTH-1:1]};
                bin_c   = a_q[0];
            end
            OP_ROL: begin
                bin_res = {a_q[WIDTH-2:0], cin_q};
                bin_c   = a_q[WIDTH-1];
            end
            OP_ROR: begin
                bin_res = {cin_q, a_q[WIDTH-1:1]};
                bin_c   = a_q[0];
            end
            OP_CMP: bin_c   = (a_q >= b_q);
            OP_INC: bin_res = a_q + WIDTH'(1);
            OP_DEC: bin_res = a_q - WIDTH'(1);
            default: ;
        endcase
        // CMP reports N/Z of the difference while returning a unchanged.
        if (op_q == OP_CMP) begin
            bin_n = diff[WIDTH-1];
            bin_z = (diff == '0);
        end else begin
            bin_n = bin_res[WIDTH-1];
            bin_z = (bin_res == '0);
        end
    end

    always_comb begin
        dec_word = (op_q == OP_SBC) ? bcd_sub(a_q, b_q, cin_q) : bcd_add(a_q, b_q, cin_q);
        go_adj   = (DECIMAL_EN != 0) && dec_q && ((op_q == OP_ADC) || (op_q == OP_SBC));
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        dec_d       = dec_q;
        result_d    = result_q;
        n_d         = n_q;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d       = op;
                    a_d        = a;
                    b_d        = b;
                    cin_d      = carry_in;
                    dec_d      = decimal;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (go_adj) begin
                    state_d = ADJ;
                end else begin
                    result_d    = bin_res;
                    n_d         = bin_n;
                    z_d         = bin_z;
                    c_d         = bin_c;
                    v_d         = bin_v;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            ADJ: begin
                result_d    = dec_word[WIDTH-1:0];
                n_d         = dec_word[WIDTH-1];
                z_d         = (dec_word[WIDTH-1:0] == '0);
                c_d         = dec_word[WIDTH];
                v_d         = bin_v;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            dec_q       <= 1'b0;
            result_q    <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            dec_q       <= dec_d;
            result_q    <= result_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq: latency, result/flags, hold
// stability, ignored requests and reset in the middle of a decimal op.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         carry_in, decimal;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         flag_n, flag_z, flag_c, flag_v;
    logic [1:0]   dbg_state;

    logic [W+3:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W), .DECIMAL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c), .flag_v(flag_v), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: integer arithmetic, word = {result, n, z, c, v}.
    function automatic logic [W+3:0] model(input int o, input int x, input int y,
                                           input int ci, input int dm);
        int r, c, v, n, z, s, yy, sx, sy, d, bw;
        logic [7:0] rb;
        c = ci; v = 0; r = x;
        case (o)
            0, 1: begin
                yy = (o == 1) ? (~y & 255) : y;
                s  = x + yy + ci;
                r  = s & 255;
                c  = (s >> 8) & 1;
                sx = (x > 127) ? x - 256 : x;
                sy = (yy > 127) ? yy - 256 : yy;
                v  = ((sx + sy + ci) > 127 || (sx + sy + ci) < -128) ? 1 : 0;
                if (dm != 0) begin
                    r = 0;
                    if (o == 0) begin
                        c = ci;
                        for (int i = 0; i < 2; i++) begin
                            d = ((x >> (4*i)) & 15) + ((y >> (4*i)) & 15) + c;
                            if (d > 9) begin d = d + 6; c = 1; end else c = 0;
                            r = r | ((d & 15) << (4*i));
                        end
                    end else begin
                        bw = (ci != 0) ? 0 : 1;
                        for (int i = 0; i < 2; i++) begin
                            d = ((x >> (4*i)) & 15) - ((y >> (4*i)) & 15) - bw;
                            if (d < 0) begin d = (d - 6) & 15; bw = 1; end else bw = 0;
                            r = r | ((d & 15) << (4*i));
                        end
                        c = 1 - bw;
                    end
                end
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin r = (x << 1) & 255; c = (x >> 7) & 1; end
            6: begin r = x >> 1; c = x & 1; end
            7: begin r = ((x << 1) | ci) & 255; c = (x >> 7) & 1; end
            8: begin r = (x >> 1) | (ci << 7); c = x & 1; end
            9: begin r = x; c = (x >= y) ? 1 : 0; end
            10: r = (x + 1) & 255;
            11: r = (x - 1) & 255;
            default: r = x;
        endcase
        if (o == 9) begin
            n = (((x - y) & 255) >> 7) & 1;
            z = (((x - y) & 255) == 0) ? 1 : 0;
        end else begin
            n = (r >> 7) & 1;
            z = (r == 0) ? 1 : 0;
        end
        rb = r[7:0];
        return {rb, n[0], z[0], c[0], v[0]};
    endfunction

    // driver + scoreboard: send one request, check latency, pop and compare,
    // hold out_ready low for `hold` cycles (optionally with a junk request),
    // then release.
    task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci, input logic dm,
                       input logic [W+3:0] expw, input int lat, input int hold,
                       input bit junk);
        int edges;
        logic [W+3:0] e;
        in_valid = 1'b1; op = o; a = x; b = y; carry_in = ci; decimal = dm;
        exp_q.push_back(expw);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (out_valid !== 1'b1 && edges < 8) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, edges, lat);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 1, 0);
                e = 'x;
            end else begin
                e = exp_q.pop_front();
            end
            check({tag, "_resp"}, {result, flag_n, flag_z, flag_c, flag_v}, e);
            if (junk) begin
                in_valid = 1'b1; op = 4'd2; a = 8'hFF; b = 8'hFF; decimal = 1'b0;
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold"}, {out_valid, in_ready, result, flag_n, flag_z, flag_c, flag_v},
                      {1'b1, 1'b0, e});
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            check({tag, "_release"}, {out_valid, in_ready, dbg_state}, {1'b0, 1'b1, 2'd0});
        end
    endtask

    initial begin
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        logic rc, rd;
        int rl;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; carry_in = 1'b0; decimal = 1'b0;
        #12;
        check("reset_outputs", {out_valid, result, flag_n, flag_z, flag_c, flag_v, dbg_state},
              {1'b0, 8'h00, 4'h0, 2'd0});
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1'b1);

        // first edge after release accepts
        run("adc_bin", 4'd0, 8'h50, 8'h50, 1'b0, 1'b0, {8'hA0, 4'b1001}, 2, 0, 1'b0);
        run("sbc_bin", 4'd1, 8'h00, 8'h01, 1'b1, 1'b0, {8'hFF, 4'b1000}, 2, 0, 1'b0);
        run("adc_dec", 4'd0, 8'h58, 8'h46, 1'b1, 1'b1, {8'h05, 4'b0011}, 3, 0, 1'b0);
        run("sbc_dec", 4'd1, 8'h12, 8'h21, 1'b1, 1'b1, {8'h91, 4'b1000}, 3, 1, 1'b0);
        run("cmp_hold", 4'd9, 8'h40, 8'h40, 1'b0, 1'b0, {8'h40, 4'b0110}, 2, 5, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check("ignored_req", {out_valid, dbg_state}, {1'b0, 2'd0});
        run("ror_cin", 4'd8, 8'h01, 8'h00, 1'b1, 1'b0, {8'h80, 4'b1010}, 2, 0, 1'b0);
        run("asl_out", 4'd5, 8'h80, 8'h00, 1'b0, 1'b0, {8'h00, 4'b0110}, 2, 0, 1'b0);
        run("inc_wrap", 4'd10, 8'hFF, 8'h00, 1'b0, 1'b0, {8'h00, 4'b0100}, 2, 0, 1'b0);
        run("dec_wrap", 4'd11, 8'h00, 8'h00, 1'b1, 1'b0, {8'hFF, 4'b1010}, 2, 0, 1'b0);
        run("reserved", 4'd13, 8'h85, 8'h12, 1'b1, 1'b1, {8'h85, 4'b1010}, 2, 0, 1'b0);
        run("and_decbit", 4'd2, 8'hF0, 8'h3C, 1'b0, 1'b1, {8'h30, 4'b0000}, 2, 0, 1'b0);
        run("adc_dec_hex", 4'd0, 8'h0F, 8'h01, 1'b0, 1'b1, {8'h16, 4'b0000}, 3, 0, 1'b0);

        // reset while in ADJ: response must be discarded
        in_valid = 1'b1; op = 4'd0; a = 8'h58; b = 8'h46; carry_in = 1'b1; decimal = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("adj_state", dbg_state, 2'd2);
        rst_n = 1'b0;
        #1;
        check("mid_reset", {out_valid, result, flag_n, flag_z, flag_c, flag_v, dbg_state},
              {1'b0, 8'h00, 4'h0, 2'd0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("no_stale", {out_valid, in_ready}, {1'b0, 1'b1});
        run("after_reset", 4'd0, 8'h01, 8'h02, 1'b0, 1'b0, {8'h03, 4'b0000}, 2, 0, 1'b0);

        // random stimulus against the reference model
        for (int k = 0; k < 40; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rl = (rd && (ro == 4'd0 || ro == 4'd1)) ? 3 : 2;
            run("random", ro, ra, rb, rc, rd, model(ro, ra, rb, rc, rd), rl,
                $urandom_range(0, 2), 1'b0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
